commit_trace_serializer: RTL and testbench

Parametrised successor to the single-bundle commit-trace interface. It captures up to NRET retirements per cycle plus an optional trap from the DUT commit port, and packs them into a circular FIFO in program order. It drains them one record per cycle over a valid/ready stream to the scoreboard / reference-model stepper. It adds sequence numbering, all-or-nothing overflow detection and halt-after-drain sequencing.

---
 rtl/commit_trace_serializer.sv | 137 +++++++++++++
 tb/tb_commit_trace_serializer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_serializer.sv
// Commit-trace serializer: packs up to NRET retirements plus a trap per cycle
// into a circular FIFO and drains one record per cycle over valid/ready.
module commit_trace_serializer #(
    parameter int NRET  = 2,
    parameter int XLEN  = 64,
    parameter int DEPTH = 16,
    parameter int SEQW  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NRET-1:0]            in_commit_valid,
    input  logic [NRET*XLEN-1:0]       in_commit_pc,
    input  logic [NRET*32-1:0]         in_commit_insn,
    input  logic                       in_trap_valid,
    input  logic [XLEN-1:0]            in_trap_code,
    input  logic                       in_halt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_insn,
    output logic                       out_trap,
    output logic [XLEN-1:0]            out_code,
    output logic [SEQW-1:0]            out_seq,
    output logic                       out_halt,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
        logic            trap;
        logic [XLEN-1:0] code;
    } rec_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    rec_t          mem [DEPTH];
    rec_t          head;
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] slotOff [NRET];
    logic [CW-1:0] cnt;
    logic [CW-1:0] cntNext;
    logic [CW-1:0] nValid;
    logic [CW-1:0] need;
    logic [CW-1:0] free;
    logic          accept;
    logic          pop;
    logic [SEQW-1:0] seq;
    logic          ovf;
    state_t        state;
    state_t        stateNext;

    // Each valid slot lands at wrPtr + (number of valid slots below it).
    always_comb begin
        nValid = '0;
        for (int i = 0; i < NRET; i++) begin
            slotOff[i] = nValid[PW-1:0];
            nValid     = nValid + CW'(in_commit_valid[i]);
        end
        need    = nValid + CW'(in_trap_valid);
        free    = CW'(DEPTH) - cnt;
        accept  = (state == RUN) && (need != '0) && (need <= free);
        pop     = (cnt != '0) && out_ready;
        cntNext = cnt + (accept ? need : '0) - CW'(pop);
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            RUN:     if (in_halt) stateNext = DRAIN;
            DRAIN:   if (cntNext == '0) stateNext = HALTED;
            HALTED:  stateNext = HALTED;
            default: stateNext = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
            seq   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (accept)
                wrPtr <= wrPtr + need[PW-1:0];
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
                seq   <= seq + 1'b1;
            end
            if (state == RUN && need > free)
                ovf <= 1'b1;
        end
    end

    // Storage needs no reset: every output is gated by a non-zero count.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NRET; i++) begin
                if (in_commit_valid[i])
                    mem[wrPtr + slotOff[i]] <= rec_t'{
                        pc:   in_commit_pc[i*XLEN +: XLEN],
                        insn: in_commit_insn[i*32 +: 32],
                        trap: 1'b0,
                        code: '0
                    };
            end
            if (in_trap_valid)
                mem[wrPtr + nValid[PW-1:0]] <= rec_t'{
                    pc:   '0,
                    insn: '0,
                    trap: 1'b1,
                    code: in_trap_code
                };
        end
    end

    assign head      = mem[rdPtr];
    assign out_valid = (cnt != '0);
    assign out_pc    = out_valid ? head.pc : '0;
    assign out_insn  = out_valid ? head.insn : '0;
    assign out_trap  = out_valid && head.trap;
    assign out_code  = out_valid ? head.code : '0;
    assign out_seq   = seq;
    assign out_halt  = (state == HALTED);
    assign overflow  = ovf;
    assign occupancy = cnt;

endmodule

// File: tb/tb_commit_trace_serializer.sv
// Scoreboard bench for commit_trace_serializer: records are queued as bundles
// are driven and compared against the head of the stream each cycle.
module tb_commit_trace_serializer;

    localparam int NRET  = 2;
    localparam int XLEN  = 64;
    localparam int DEPTH = 16;
    localparam int SEQW  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NRET-1:0]   in_commit_valid = '0;
    logic [NRET*XLEN-1:0] in_commit_pc = '0;
    logic [NRET*32-1:0]   in_commit_insn = '0;
    logic              in_trap_valid = 1'b0;
    logic [XLEN-1:0]   in_trap_code = '0;
    logic              in_halt = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [XLEN-1:0]   out_pc;
    logic [31:0]       out_insn;
    logic              out_trap;
    logic [XLEN-1:0]   out_code;
    logic [SEQW-1:0]   out_seq;
    logic              out_halt;
    logic              overflow;
    logic [4:0]        occupancy;

    commit_trace_serializer #(
        .NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH), .SEQW(SEQW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_commit_valid(in_commit_valid),
        .in_commit_pc(in_commit_pc),
        .in_commit_insn(in_commit_insn),
        .in_trap_valid(in_trap_valid),
        .in_trap_code(in_trap_code),
        .in_halt(in_halt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_insn(out_insn),
        .out_trap(out_trap), .out_code(out_code),
        .out_seq(out_seq), .out_halt(out_halt),
        .overflow(overflow), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
        logic            trap;
        logic [XLEN-1:0] code;
    } rec_t;

    rec_t        q[$];
    logic [SEQW-1:0] mSeq;
    bit          mOvf;
    int          mState;
    int          nVec;
    int          nMiss;

    task automatic checkEq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
        nVec++;
        if (got !== exp) begin
            nMiss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [63:0] p0,
                         input logic [63:0] p1, input logic t,
                         input logic [63:0] c, input logic h);
        in_commit_valid = v;
        in_commit_pc    = {p1, p0};
        in_commit_insn  = {p1[31:0] ^ 32'h13, p0[31:0] ^ 32'h13};
        in_trap_valid   = t;
        in_trap_code    = c;
        in_halt         = h;
    endtask

    task automatic idle();
        drive(2'b00, 64'h0, 64'h0, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic resetModel();
        q.delete();
        mSeq   = '0;
        mOvf   = 1'b0;
        mState = 0;
    endtask

    // Check outputs mid-cycle, then apply this cycle's bundle to the model.
    task automatic tick();
        int  need;
        int  freeSlots;
        bit  pop;
        rec_t r;
        #1;
        checkEq("valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            checkEq("pc", out_pc, q[0].pc);
            checkEq("insn", out_insn, q[0].insn);
            checkEq("trap", out_trap, q[0].trap);
            checkEq("code", out_code, q[0].code);
            checkEq("seq", out_seq, mSeq);
        end
        checkEq("occ", occupancy, q.size());
        checkEq("ovf", overflow, mOvf);
        checkEq("halt", out_halt, mState == 2);
        freeSlots = DEPTH - q.size();
        pop  = (q.size() != 0) && out_ready;
        need = int'(in_commit_valid[0]) + int'(in_commit_valid[1])
             + int'(in_trap_valid);
        if (pop) begin
            void'(q.pop_front());
            mSeq = mSeq + 1'b1;
        end
        if (mState == 0) begin
            if (need > freeSlots)
                mOvf = 1'b1;
            else if (need != 0) begin
                for (int i = 0; i < NRET; i++) begin
                    if (in_commit_valid[i]) begin
                        r.pc   = in_commit_pc[i*XLEN +: XLEN];
                        r.insn = in_commit_insn[i*32 +: 32];
                        r.trap = 1'b0;
                        r.code = '0;
                        q.push_back(r);
                    end
                end
                if (in_trap_valid) begin
                    r.pc = '0; r.insn = '0; r.trap = 1'b1;
                    r.code = in_trap_code;
                    q.push_back(r);
                end
            end
            if (in_halt) mState = 1;
        end else if (mState == 1 && q.size() == 0) begin
            mState = 2;
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted and released between clock edges.
    task automatic doReset();
        #2 rst_n = 1'b0;
        #1;
        checkEq("rst_valid", out_valid, 1'b0);
        checkEq("rst_occ", occupancy, 5'd0);
        checkEq("rst_pc", out_pc, 64'h0);
        checkEq("rst_ovf", overflow, 1'b0);
        checkEq("rst_halt", out_halt, 1'b0);
        checkEq("rst_seq", out_seq, 64'h0);
        resetModel();
        idle();
        out_ready = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        nVec = 0;
        nMiss = 0;
        resetModel();
        #3;
        checkEq("init_occ", occupancy, 5'd0);
        checkEq("init_valid", out_valid, 1'b0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two-slot bundle drains in slot order.
        out_ready = 1'b1;
        drive(2'b11, 64'h1000, 64'h1004, 1'b0, 64'h0, 1'b0);
        tick();
        idle();
        #1;
        checkEq("t1_pc0", out_pc, 64'h1000);
        checkEq("t1_seq0", out_seq, 64'd0);
        tick();
        tick();
        tick();

        // Sparse slot plus trap.
        drive(2'b10, 64'h0, 64'h2000, 1'b1, 64'h2, 1'b0);
        tick();
        idle();
        tick();
        tick();
        tick();

        // Backpressure: fill to 16, then one more is dropped.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(2'b01, 64'h3000 + 64'(4 * i), 64'h0, 1'b0, 64'h0, 1'b0);
            tick();
        end
        drive(2'b01, 64'h3ff0, 64'h0, 1'b0, 64'h0, 1'b0);
        #1;
        checkEq("bp_full", occupancy, 5'd16);
        tick();
        idle();
        #1;
        checkEq("bp_ovf", overflow, 1'b1);
        checkEq("bp_head", out_pc, 64'h3000);
        tick();
        doReset();

        // All-or-nothing at count 15.
        for (int i = 0; i < DEPTH - 1; i++) begin
            drive(2'b01, 64'h4000 + 64'(4 * i), 64'h0, 1'b0, 64'h0, 1'b0);
            tick();
        end
        drive(2'b11, 64'h5000, 64'h5004, 1'b0, 64'h0, 1'b0);
        tick();
        idle();
        #1;
        checkEq("aon_occ", occupancy, 5'd15);
        checkEq("aon_ovf", overflow, 1'b1);
        tick();
        doReset();

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            drive(2'($urandom_range(0, 3)),
                  {32'h0, $urandom}, {32'h0, $urandom},
                  1'($urandom_range(0, 5) == 0),
                  64'($urandom_range(1, 15)), 1'b0);
            tick();
        end
        idle();
        doReset();

        // Halt: three queued, halt bundle accepted, later inputs ignored.
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 64'h6000 + 64'(4 * i), 64'h0, 1'b0, 64'h0, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        drive(2'b01, 64'h7000, 64'h0, 1'b0, 64'h0, 1'b1);
        tick();
        drive(2'b11, 64'h8000, 64'h8004, 1'b1, 64'h9, 1'b0);
        for (int k = 0; k < 20 && mState != 2; k++)
            tick();
        tick();
        checkEq("halt_up", out_halt, 1'b1);
        checkEq("halt_occ", occupancy, 5'd0);
        tick();
        idle();
        doReset();

        // Reset mid-drain, then sequence restarts at zero.
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 64'hA000 + 64'(8 * i), 64'hA004 + 64'(8 * i),
                  1'b0, 64'h0, 1'b0);
            tick();
        end
        idle();
        out_ready = 1'b1;
        tick();
        tick();
        doReset();
        out_ready = 1'b1;
        drive(2'b01, 64'hB000, 64'h0, 1'b0, 64'h0, 1'b0);
        tick();
        idle();
        #1;
        checkEq("rs_pc", out_pc, 64'hB000);
        checkEq("rs_seq", out_seq, 64'd0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
